ttl_parity_accumulator: RTL

Multi-channel clocked parity accumulator for the 7400-series library. Each of BLOCKS channels XOR-reduces a WIDTH_IN-bit input word every enabled clock. It folds that bit into a running parity over a frame of WORDS words, then presents the per-channel frame parity (even or odd sense) with a one-cycle Valid strobe. It extends the combinational quad-XOR family to framed, sequential parity generation and checking on serial/word buses.

---
 rtl/ttl_parity_accumulator_pkg.sv | 30 +++
 rtl/ttl_parity_accumulator_7486.sv | 27 ++
 rtl/ttl_parity_accumulator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ttl_parity_accumulator_pkg.sv
// Shared definitions for the framed parity accumulator: state encoding and the
// flattened-bus unpack helper macro.
`ifndef TTL_PARITY_ACCUMULATOR_PKG_SV
`define TTL_PARITY_ACCUMULATOR_PKG_SV

// Unpacks PK_SRC (PK_LEN fields of PK_WIDTH bits) into unpacked array UNPK_DEST.
`define ASSIGN_UNPACK_ARRAY(PK_LEN, PK_WIDTH, UNPK_DEST, PK_SRC) \
  for (genvar unpk_idx = 0; unpk_idx < (PK_LEN); unpk_idx++) begin : gen_unpack \
    assign UNPK_DEST[unpk_idx] = PK_SRC[(PK_WIDTH)*unpk_idx +: (PK_WIDTH)]; \
  end

package ttl_parity_accumulator_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ACCUM = ACCUM,
    ST_DONE  = DONE
  } state_e;

  function automatic int count_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

`endif

// File: rtl/ttl_parity_accumulator_7486.sv
// ttl_7486: per-channel XOR reduction of a flattened multi-channel word.
module ttl_7486 #(
  parameter int BLOCKS     = 4,
  parameter int WIDTH_IN   = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y
);

  logic [WIDTH_IN-1:0] a [BLOCKS];
  logic [BLOCKS-1:0]   par;

  `ASSIGN_UNPACK_ARRAY(BLOCKS, WIDTH_IN, a, A_2D)

  for (genvar i = 0; i < BLOCKS; i++) begin : gen_lane
    assign par[i] = ^a[i];
  end

  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : gen_nodly
    assign Y = par;
  end else begin : gen_dly
    assign #(DELAY_RISE, DELAY_FALL) Y = par;
  end

endmodule

// File: rtl/ttl_parity_accumulator.sv
// Framed multi-channel parity accumulator (IDLE -> ACCUM -> DONE).
// Optional Expected/Error checking is built when TTL_PARITY_CHECK_EN is defined.
module ttl_parity_accumulator
  import ttl_parity_accumulator_pkg::*;
#(
  parameter int BLOCKS     = 4,
  parameter int WIDTH_IN   = 2,
  parameter int WORDS      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                       Clk,
  input  logic                       Clear,
  input  logic                       Start,
  input  logic                       Enable,
  input  logic                       Odd,
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
`ifdef TTL_PARITY_CHECK_EN
  input  logic [BLOCKS-1:0]          Expected,
  output logic [BLOCKS-1:0]          Error,
`endif
  output logic [BLOCKS-1:0]          Y,
  output logic                       Valid,
  output logic                       Busy
);

  localparam int CW = count_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_e            state, state_d;
  logic [BLOCKS-1:0] acc, acc_d;
  logic [CW-1:0]     count, count_d;
  logic [BLOCKS-1:0] y_q, y_d;
  logic              valid_q, busy_q;
  logic [BLOCKS-1:0] word_par;

  ttl_7486 #(
    .BLOCKS     (BLOCKS),
    .WIDTH_IN   (WIDTH_IN),
    .DELAY_RISE (0),
    .DELAY_FALL (0)
  ) u_xor (
    .A_2D (A_2D),
    .Y    (word_par)
  );

  always_comb begin
    state_d = state;
    acc_d   = acc;
    count_d = count;
    y_d     = y_q;
    case (state)
      ST_IDLE: if (Start) begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        count_d = '0;
      end
      ST_ACCUM: begin
        if (Start) begin
          acc_d   = '0;
          count_d = '0;
        end else if (Enable) begin
          if (count == LAST) begin
            y_d     = acc ^ word_par ^ {BLOCKS{Odd}};
            acc_d   = '0;
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            acc_d   = acc ^ word_par;
            count_d = count + 1'b1;
          end
        end
      end
      ST_DONE: begin
        acc_d   = '0;
        count_d = '0;
        state_d = Start ? ST_ACCUM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state   <= ST_IDLE;
      acc     <= '0;
      count   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      count   <= count_d;
      y_q     <= y_d;
      valid_q <= (state_d == ST_DONE);
      busy_q  <= (state_d == ST_ACCUM);
    end
  end

`ifdef TTL_PARITY_CHECK_EN
  logic [BLOCKS-1:0] err_q;

  // Only a completion moves y_d into the DONE state, so that is the sole update point.
  always_ff @(posedge Clk) begin
    if (Clear)
      err_q <= '0;
    else if (state == ST_ACCUM && state_d == ST_DONE)
      err_q <= y_d ^ Expected;
  end
`endif

  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : gen_nodly
    assign Y     = y_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;
`ifdef TTL_PARITY_CHECK_EN
    assign Error = err_q;
`endif
  end else begin : gen_dly
    assign #(DELAY_RISE, DELAY_FALL) Y     = y_q;
    assign #(DELAY_RISE, DELAY_FALL) Valid = valid_q;
    assign #(DELAY_RISE, DELAY_FALL) Busy  = busy_q;
`ifdef TTL_PARITY_CHECK_EN
    assign #(DELAY_RISE, DELAY_FALL) Error = err_q;
`endif
  end

endmodule
